// File: rtl/frame_capture_writer.sv
// Camera capture front end: assembles RGB565 pixels from a byte stream and
// writes them into a linear frame buffer, flagging complete and short frames.
module frame_capture_writer #(
  parameter int unsigned H_PIXELS = 320,
  parameter int unsigned V_PIXELS = 240,
  localparam int unsigned FRAME_SIZE = H_PIXELS * V_PIXELS,
  localparam int unsigned ADDR_W = $clog2(FRAME_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_byte_valid,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done_toggle,
  output logic              frame_err
);

  localparam int unsigned X_W   = $clog2(H_PIXELS + 1);
  localparam int unsigned Y_W   = $clog2(V_PIXELS + 1);
  localparam int unsigned CNT_W = $clog2(FRAME_SIZE + 1);

  localparam logic [X_W-1:0]   X_MAX     = X_W'(H_PIXELS);
  localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(V_PIXELS);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_SIZE);
  localparam logic [CNT_W-1:0] BASE_STEP = CNT_W'(H_PIXELS);

  typedef enum logic [1:0] {WAIT_SYNC, WAIT_START, CAPTURE} state_t;

  state_t             state, state_d;
  logic               vsync_q, href_q;
  logic               phase, phase_d;
  logic [7:0]         hi_byte, hi_byte_d;
  logic [X_W-1:0]     x, x_d;
  logic [Y_W-1:0]     y, y_d;
  logic [CNT_W-1:0]   line_base, line_base_d;
  logic [CNT_W-1:0]   pix_cnt, pix_cnt_d;
  logic               wr_en_d, frame_done_toggle_d, frame_err_d;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [15:0]        wr_data_d;

  logic vsync_rise, vsync_fall, href_fall;
  assign vsync_rise = cam_vsync & ~vsync_q;
  assign vsync_fall = ~cam_vsync & vsync_q;
  assign href_fall  = ~cam_href & href_q;

  // State, sync copies and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= WAIT_SYNC;
      vsync_q           <= 1'b0;
      href_q            <= 1'b0;
      phase             <= 1'b0;
      hi_byte           <= 8'd0;
      x                 <= '0;
      y                 <= '0;
      line_base         <= '0;
      pix_cnt           <= '0;
      wr_en             <= 1'b0;
      wr_addr           <= '0;
      wr_data           <= 16'd0;
      frame_done_toggle <= 1'b0;
      frame_err         <= 1'b0;
    end else begin
      state             <= state_d;
      vsync_q           <= cam_vsync;
      href_q            <= cam_href;
      phase             <= phase_d;
      hi_byte           <= hi_byte_d;
      x                 <= x_d;
      y                 <= y_d;
      line_base         <= line_base_d;
      pix_cnt           <= pix_cnt_d;
      wr_en             <= wr_en_d;
      wr_addr           <= wr_addr_d;
      wr_data           <= wr_data_d;
      frame_done_toggle <= frame_done_toggle_d;
      frame_err         <= frame_err_d;
    end
  end

  // Next state, pixel assembly and frame bookkeeping
  always_comb begin
    state_d             = state;
    phase_d             = phase;
    hi_byte_d           = hi_byte;
    x_d                 = x;
    y_d                 = y;
    line_base_d         = line_base;
    pix_cnt_d           = pix_cnt;
    wr_en_d             = 1'b0;
    wr_addr_d           = wr_addr;
    wr_data_d           = wr_data;
    frame_done_toggle_d = frame_done_toggle;
    frame_err_d         = 1'b0;

    case (state)
      WAIT_SYNC: begin
        if (vsync_rise) state_d = WAIT_START;
      end
      WAIT_START: begin
        if (vsync_fall) begin
          state_d     = CAPTURE;
          phase_d     = 1'b0;
          x_d         = '0;
          y_d         = '0;
          line_base_d = '0;
          pix_cnt_d   = '0;
        end
      end
      CAPTURE: begin
        if (cam_href && cam_byte_valid) begin
          if (!phase) begin
            hi_byte_d = cam_data;
            phase_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x < X_MAX && y < Y_MAX) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ADDR_W'(line_base + CNT_W'(x));
              wr_data_d = {hi_byte, cam_data};
              pix_cnt_d = pix_cnt + CNT_W'(1);
            end
            // x saturates at the line width so over-long lines cannot wrap
            if (x < X_MAX) x_d = x + X_W'(1);
          end
        end
        if (href_fall) begin
          phase_d = 1'b0;
          x_d     = '0;
          if (x != '0 && y < Y_MAX) begin
            y_d         = y + Y_W'(1);
            line_base_d = line_base + BASE_STEP;
          end
        end
        // Uses pix_cnt_d so a pixel completing on the vsync edge is counted
        if (vsync_rise) begin
          state_d = WAIT_START;
          if (pix_cnt_d == CNT_FULL) frame_done_toggle_d = ~frame_done_toggle;
          else                       frame_err_d = 1'b1;
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

endmodule

// File: tb/tb_frame_capture_writer.sv
// Randomized bench for frame_capture_writer on a reduced frame geometry,
// checked against a per-line pixel/address model.
module tb_frame_capture_writer;

  localparam int unsigned H     = 16;
  localparam int unsigned V     = 6;
  localparam int unsigned FRAME = H * V;
  localparam int unsigned AW    = $clog2(FRAME);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic          cam_byte_valid = 1'b0;
  logic [7:0]    cam_data = 8'd0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done_toggle;
  logic          frame_err;

  frame_capture_writer #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk               (clk),
    .reset             (reset),
    .cam_vsync         (cam_vsync),
    .cam_href          (cam_href),
    .cam_byte_valid    (cam_byte_valid),
    .cam_data          (cam_data),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .frame_done_toggle (frame_done_toggle),
    .frame_err         (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Model state
  bit          m_active = 1'b0;
  int          m_y = 0;
  int          m_writes = 0;
  logic        exp_toggle = 1'b0;
  int          exp_err_total = 0;

  // Monitor observations
  int          got_writes = 0;
  int          tog_chg = 0;
  int          err_seen = 0;
  logic        prev_tog = 1'b0;
  logic [31:0] last_addr = 32'd0;
  int          wr_base = 0;
  int          tog_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        got_writes++;
        last_addr = 32'(wr_addr);
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), mon_e.addr);
          check("wr_data", 32'(wr_data), 32'(mon_e.data));
          check("wr_latency", cyc, mon_e.cyc);
        end
      end
      if (frame_err) err_seen++;
      if (frame_done_toggle !== prev_tog) tog_chg++;
    end
    prev_tog = frame_done_toggle;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_toggle", 32'(frame_done_toggle), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    exp_q.delete();
    m_active   = 1'b0;
    exp_toggle = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Pixel p of a line is bytes {2p, 2p+1}; written only inside the frame geometry
  task automatic send_line(input int nbytes, input bit gaps, input bit vsync_last);
    logic [7:0] hi;
    exp_t e;
    int p;
    hi = 8'd0;
    @(negedge clk);
    cam_href = 1'b1;
    cam_byte_valid = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          cam_byte_valid = 1'b0;
        end
      end
      @(negedge clk);
      cam_byte_valid = 1'b1;
      cam_data = 8'($urandom);
      if (vsync_last && i == nbytes - 1) cam_vsync = 1'b1;
      if (i % 2 == 0) begin
        hi = cam_data;
      end else if (m_active) begin
        p = i / 2;
        if (p < int'(H) && m_y < int'(V)) begin
          e.addr = 32'(m_y * int'(H) + p);
          e.data = {hi, cam_data};
          e.cyc  = cyc + 1;
          exp_q.push_back(e);
          m_writes++;
        end
      end
    end
    if (!vsync_last) begin
      @(negedge clk);
      cam_byte_valid = 1'b0;
      cam_href = 1'b0;
      repeat (2) @(negedge clk);
    end
    if (m_active && nbytes >= 2 && m_y < int'(V)) m_y++;
  endtask

  task automatic start_frame();
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cam_vsync = 1'b0;
    m_active = 1'b1;
    m_y      = 0;
    m_writes = 0;
    wr_base  = got_writes;
    tog_base = tog_chg;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_frame(input bit already);
    bit full;
    full = (m_writes == int'(FRAME));
    if (!already) begin
      @(negedge clk);
      cam_vsync = 1'b1;
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_byte_valid = 1'b0;
    if (m_active) begin
      if (full) exp_toggle = ~exp_toggle;
      else      exp_err_total++;
    end
    check("frame_done_toggle", 32'(frame_done_toggle), 32'(exp_toggle));
    check("frame_err", 32'(frame_err), 32'(m_active && !full));
    @(negedge clk);
    check("frame_err_width", 32'(frame_err), 32'd0);
    repeat (2) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("toggle_changes", 32'(tog_chg - tog_base), 32'(m_active && full));
    check("err_total", 32'(err_seen), 32'(exp_err_total));
    if (m_active) check("frame_writes", 32'(got_writes - wr_base), 32'(m_writes));
    m_active = 1'b0;
  endtask

  initial begin
    do_reset();

    // Startup mid-frame: vsync low at release, nothing may be written
    repeat (2) send_line(2 * H, 1'b0, 1'b0);
    end_frame(1'b0);

    // Full frame, no gaps
    start_frame();
    repeat (V) send_line(2 * H, 1'b0, 1'b0);
    end_frame(1'b0);

    // Full frame with random byte_valid gaps
    start_frame();
    repeat (V) send_line(2 * H, 1'b1, 1'b0);
    end_frame(1'b0);

    // Over-long lines and extra lines
    start_frame();
    repeat (V + 2) send_line(2 * H + 20, 1'b0, 1'b0);
    end_frame(1'b0);
    check("overlong_last_addr", last_addr, 32'(FRAME - 1));

    // Short frame
    start_frame();
    repeat (V - 1) send_line(2 * H, 1'b0, 1'b0);
    end_frame(1'b0);

    // Odd byte count on the first line
    start_frame();
    send_line(2 * H + 1, 1'b1, 1'b0);
    repeat (V - 1) send_line(2 * H, 1'b0, 1'b0);
    end_frame(1'b0);

    // Last pixel completes on the vsync rising edge
    start_frame();
    repeat (V - 1) send_line(2 * H, 1'b0, 1'b0);
    send_line(2 * H, 1'b0, 1'b1);
    end_frame(1'b1);

    // Reset mid-frame, then a complete frame
    start_frame();
    repeat (2) send_line(2 * H, 1'b0, 1'b0);
    do_reset();
    repeat (2) send_line(2 * H, 1'b0, 1'b0);
    end_frame(1'b0);
    start_frame();
    repeat (V) send_line(2 * H, 1'b1, 1'b0);
    end_frame(1'b0);

    // Random geometry frames
    for (int f = 0; f < 6; f++) begin
      int nlines;
      start_frame();
      nlines = int'($urandom_range(V - 1, V + 1));
      for (int l = 0; l < nlines; l++)
        send_line(int'($urandom_range(2 * H - 3, 2 * H + 4)), 1'b1, 1'b0);
      end_frame(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_capture_writer.md
FRAME_CAPTURE_WRITER -- requirements
Module: frame_capture_writer

Interface
REQ-001 SHALL have parameters H_PIXELS=320 (pixels per line) and V_PIXELS=240 (lines per frame); FRAME_SIZE=H_PIXELS*V_PIXELS.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on posedge clk.
REQ-003 SHALL have port reset, input, 1; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port cam_vsync, input, 1, camera vertical sync, clk-synchronous; high = vertical blanking.
REQ-005 SHALL have port cam_href, input, 1, camera line-valid, clk-synchronous.
REQ-006 SHALL have port cam_byte_valid, input, 1, qualifies cam_data for one clk.
REQ-007 SHALL have port cam_data, input, 8, camera byte, RGB565 high byte first.
REQ-008 SHALL have port wr_en, output, 1, frame-buffer write strobe.
REQ-009 SHALL have port wr_addr, output, $clog2(FRAME_SIZE), frame-buffer write address.
REQ-010 SHALL have port wr_data, output, 16, RGB565 pixel.
REQ-011 SHALL have port frame_done_toggle, output, 1, inverts once per complete frame; consumed by the frame analyzer's edge detector.
REQ-012 SHALL have port frame_err, output, 1, one-clk pulse on a short or aborted frame.

Function
REQ-013 SHALL register cam_vsync and cam_href once each; edges are detected by comparing current input to its registered copy.
REQ-014 SHALL implement states WAIT_SYNC, WAIT_START, CAPTURE.
REQ-015 WAIT_SYNC -> WAIT_START on vsync rising edge; WAIT_START -> CAPTURE on vsync falling edge; CAPTURE -> WAIT_START on vsync rising edge.
REQ-016 In CAPTURE only, while cam_href=1 and cam_byte_valid=1, bytes SHALL alternate phase: phase 0 latches high byte, phase 1 forms pixel {high, cam_data}.
REQ-017 Byte phase SHALL clear to 0 on every href falling edge and on entry to CAPTURE; a dangling phase-0 byte at line end is discarded.
REQ-018 For a pixel formed with x < H_PIXELS and y < V_PIXELS, the next clk SHALL have wr_en=1, wr_data=pixel, wr_addr=line_base+x (latency 1 clk from phase-1 byte).
REQ-019 Pixels with x >= H_PIXELS or lines with y >= V_PIXELS SHALL be dropped with no write.
REQ-020 x SHALL increment per formed pixel and clear on href falling edge; on href falling edge with x>0, y SHALL increment and line_base SHALL add H_PIXELS (saturating once y=V_PIXELS).
REQ-021 wr_en SHALL be 0 in all cycles other than REQ-018 writes; wr_addr/wr_data hold last values when wr_en=0.
REQ-022 A written-pixel counter SHALL count wr_en pulses per frame and clear, with x, y, line_base, on entry to CAPTURE.
REQ-023 On vsync rising edge in CAPTURE: counter==FRAME_SIZE -> frame_done_toggle inverts next clk; otherwise frame_err pulses one clk and no toggle.
REQ-024 frame_done_toggle SHALL change at most once per frame and never in WAIT_SYNC/WAIT_START.
REQ-025 A vsync rising edge coinciding with a phase-1 byte SHALL complete that pixel write before evaluating REQ-023 (write counted).

Reset
REQ-026 reset=0 SHALL immediately force: state WAIT_SYNC, wr_en=0, wr_addr=0, wr_data=0, frame_done_toggle=0, frame_err=0, x=y=line_base=counter=0, phase=0, sync registers=0.
REQ-027 Reset asserted mid-CAPTURE SHALL abandon the frame with no toggle and no frame_err; capture restarts only after a full vsync high-then-low sequence.

Verification
REQ-028 Full frame: vsync pulse, 240 lines x 640 valid bytes (pixel value = addr) -> 76800 writes, wr_addr 0..76799 monotonic, wr_data==wr_addr[15:0], frame_done_toggle 0->1 once.
REQ-029 Over-long: lines of 660 bytes, 250 lines -> exactly 76800 writes, last wr_addr=76799, toggle once, no frame_err.
REQ-030 Short: 239 full lines then vsync rise -> 76480 writes, frame_err 1 clk, toggle unchanged.
REQ-031 Odd bytes: line with 641 bytes -> 320 writes, next line starts wr_addr=line_base, first pixel uses next line's first two bytes.
REQ-032 Gaps: cam_byte_valid toggled randomly within href -> same addresses/data as REQ-028, wr_en one clk after each phase-1 byte.
REQ-033 Reset at line 100 then complete frame -> no toggle for aborted frame, next frame toggles once starting wr_addr=0; startup mid-frame (vsync low at reset release) -> no writes until vsync high-then-low.
